// File: rtl/dmem_arbiter_if.sv
// Bundle for the data-memory arbiter: CPU port, DMA port and the shared memory port.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface dmem_arbiter_if;
    logic        cpu_mem_r;
    logic        cpu_mem_w;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [31:0] dma_rdata;
    logic        dma_ack;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        owner;

    modport slave (
        input  cpu_mem_r, cpu_mem_w, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  m_rdata, m_ready,
        output cpu_rdata, cpu_stall, dma_rdata, dma_ack,
        output m_req, m_we, m_addr, m_wdata, owner
    );

    modport master (
        output cpu_mem_r, cpu_mem_w, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output m_rdata, m_ready,
        input  cpu_rdata, cpu_stall, dma_rdata, dma_ack,
        input  m_req, m_we, m_addr, m_wdata, owner
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose: arbitrates CPU and DMA onto one memory port; DMEM_ARB_RR_EN selects round-robin over fixed priority.
// Latency: grant one edge after request, done/ack one edge after m_ready; one idle cycle between m_req pulses.
// Backpressure: memory stalls via m_ready low (no timeout); CPU held by cpu_stall, DMA holds until dma_ack.
module dmem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave dm
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state_q;
    logic        m_req_q, m_we_q, cpu_done_q, dma_ack_q, owner_q;
    logic [31:0] m_addr_q, m_wdata_q, cpu_rdata_q, dma_rdata_q;
    logic        cpu_req, cpu_elig, dma_elig, pick_dma, grant;
`ifdef DMEM_ARB_RR_EN
    logic        turn_q, turn_d;
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0]  starve_q, starve_d;
`endif

    // Priority is decided on raw requests; if the chosen side is ineligible this cycle
    // (its done/ack is high) nobody is granted rather than handing the slot to the other side.
    always_comb begin
        cpu_req  = dm.cpu_mem_r | dm.cpu_mem_w;
        cpu_elig = cpu_req & ~cpu_done_q;
        dma_elig = dm.dma_req & ~dma_ack_q;
`ifdef DMEM_ARB_RR_EN
        pick_dma = dm.dma_req & (~cpu_req | turn_q);
        turn_d   = ~pick_dma;
`else
        pick_dma = dm.dma_req & (~cpu_req | (starve_q == STARVE_LIM));
        starve_d = starve_q;
        if (pick_dma) begin
            starve_d = '0;
        end else if (dm.dma_req && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
`endif
        grant = (state_q == IDLE) & (pick_dma ? dma_elig : cpu_elig);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            m_req_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            dma_ack_q   <= 1'b0;
            owner_q     <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            turn_q      <= 1'b0;
`else
            starve_q    <= '0;
`endif
        end else begin
            cpu_done_q <= 1'b0;
            dma_ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q   <= BUSY;
                        m_req_q   <= 1'b1;
                        owner_q   <= pick_dma;
                        m_we_q    <= pick_dma ? dm.dma_we    : dm.cpu_mem_w;
                        m_addr_q  <= pick_dma ? dm.dma_addr  : dm.cpu_addr;
                        m_wdata_q <= pick_dma ? dm.dma_wdata : dm.cpu_wdata;
`ifdef DMEM_ARB_RR_EN
                        turn_q    <= turn_d;
`else
                        starve_q  <= starve_d;
`endif
                    end
                end
                BUSY: begin
                    if (dm.m_ready) begin
                        state_q <= IDLE;
                        m_req_q <= 1'b0;
                        if (owner_q) begin
                            dma_ack_q <= 1'b1;
                            if (!m_we_q) dma_rdata_q <= dm.m_rdata;
                        end else begin
                            cpu_done_q <= 1'b1;
                            if (!m_we_q) cpu_rdata_q <= dm.m_rdata;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dm.cpu_stall = cpu_req & ~cpu_done_q;
    assign dm.cpu_rdata = cpu_rdata_q;
    assign dm.dma_rdata = dma_rdata_q;
    assign dm.dma_ack   = dma_ack_q;
    assign dm.m_req     = m_req_q;
    assign dm.m_we      = m_we_q;
    assign dm.m_addr    = m_addr_q;
    assign dm.m_wdata   = m_wdata_q;
    assign dm.owner     = owner_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: memory responder with programmable wait states and a grant log.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if dm ();
    dmem_arbiter #(.STARVE_MAX(4)) dut (.clk(clk), .reset(reset), .dm(dm));

    int          n_cmp = 0;
    int          n_bad = 0;
    int          mem_wait = 0;
    logic        mem_auto = 1'b1;
    logic        man_ready = 1'b0;
    logic [31:0] mem_data = '0;
    int          busy_cnt = 0;
    logic        prev_req = 1'b0;
    logic        grants[$];
    int          ack_cnt = 0;
    logic        exp_order[10];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory responder: raises m_ready after mem_wait BUSY cycles.
    always @(negedge clk) begin
        if (dm.m_req) begin
            dm.m_ready = mem_auto ? (busy_cnt >= mem_wait) : man_ready;
            busy_cnt++;
        end else begin
            dm.m_ready = mem_auto ? 1'b0 : man_ready;
            busy_cnt = 0;
        end
        dm.m_rdata = mem_data;
    end

    always @(negedge clk) begin
        if (dm.m_req && !prev_req) grants.push_back(dm.owner);
        prev_req = dm.m_req;
        if (dm.dma_ack) ack_cnt++;
    end

    task automatic wait_stall_low(output int cycles);
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!dm.cpu_stall) break;
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        int          cyc;
        int          req_cycles;
        int          unstable;
        int          ack0;
        logic        seen;
        logic        g;

        dm.cpu_mem_r = 0; dm.cpu_mem_w = 0; dm.cpu_addr = '0; dm.cpu_wdata = '0;
        dm.dma_req = 0; dm.dma_we = 0; dm.dma_addr = '0; dm.dma_wdata = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_m_req", 32'(dm.m_req), 32'd0);
        check_eq("rst_m_we", 32'(dm.m_we), 32'd0);
        check_eq("rst_m_addr", dm.m_addr, 32'd0);
        check_eq("rst_m_wdata", dm.m_wdata, 32'd0);
        check_eq("rst_cpu_rdata", dm.cpu_rdata, 32'd0);
        check_eq("rst_dma_rdata", dm.dma_rdata, 32'd0);
        check_eq("rst_dma_ack", 32'(dm.dma_ack), 32'd0);
        check_eq("rst_owner", 32'(dm.owner), 32'd0);
        check_eq("rst_stall", 32'(dm.cpu_stall), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // CPU load, zero-wait memory
        mem_wait = 0; mem_data = 32'hDEADBEEF;
        dm.cpu_mem_r = 1; dm.cpu_addr = 32'h100;
        wait_stall_low(cyc);
        check_eq("ld_stall_cycles", 32'(cyc), 32'd2);
        check_eq("ld_rdata", dm.cpu_rdata, 32'hDEADBEEF);
        check_eq("ld_m_addr", dm.m_addr, 32'h100);
        check_eq("ld_owner", 32'(dm.owner), 32'd0);
        dm.cpu_mem_r = 0;
        repeat (2) @(negedge clk);

        // DMA write with 3 wait states
        mem_wait = 3; mem_data = 32'hCAFEF00D;
        dm.dma_req = 1; dm.dma_we = 1; dm.dma_addr = 32'h200; dm.dma_wdata = 32'h12345678;
        ack0 = ack_cnt; req_cycles = 0; unstable = 0; seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (dm.m_req) begin
                req_cycles++;
                if (dm.m_addr !== 32'h200 || dm.m_wdata !== 32'h12345678 || dm.m_we !== 1'b1) unstable++;
            end
            if (dm.dma_ack) seen = 1;
        end
        dm.dma_req = 0; dm.dma_we = 0;
        check_eq("dw_ack_seen", 32'(seen), 32'd1);
        check_eq("dw_busy_cycles", 32'(req_cycles), 32'd4);
        check_eq("dw_unstable", 32'(unstable), 32'd0);
        check_eq("dw_owner", 32'(dm.owner), 32'd1);
        check_eq("dw_dma_rdata", dm.dma_rdata, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("dw_ack_pulses", 32'(ack_cnt - ack0), 32'd1);

        // Load+store together issues as a store
        mem_wait = 0; mem_data = 32'h5555AAAA;
        dm.cpu_mem_r = 1; dm.cpu_mem_w = 1; dm.cpu_addr = 32'h40; dm.cpu_wdata = 32'hA5A5A5A5;
        wait_stall_low(cyc);
        check_eq("rw_stall_cycles", 32'(cyc), 32'd2);
        check_eq("rw_m_we", 32'(dm.m_we), 32'd1);
        check_eq("rw_m_addr", dm.m_addr, 32'h40);
        check_eq("rw_m_wdata", dm.m_wdata, 32'hA5A5A5A5);
        check_eq("rw_cpu_rdata", dm.cpu_rdata, 32'hDEADBEEF);
        dm.cpu_mem_r = 0; dm.cpu_mem_w = 0;
        repeat (2) @(negedge clk);

        // Reset mid-BUSY, then a late m_ready
        mem_auto = 0; man_ready = 0; mem_data = 32'h0BADF00D;
        dm.dma_req = 1; dm.dma_we = 0; dm.dma_addr = 32'h500;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (dm.m_req) seen = 1;
        end
        check_eq("rb_busy_reached", 32'(seen), 32'd1);
        ack0 = ack_cnt;
        @(negedge clk);
        reset = 1; dm.dma_req = 0;
        @(negedge clk);
        reset = 0; man_ready = 1;
        @(negedge clk);
        man_ready = 0;
        repeat (2) @(negedge clk);
        check_eq("rb_ack_pulses", 32'(ack_cnt - ack0), 32'd0);
        check_eq("rb_m_req", 32'(dm.m_req), 32'd0);
        check_eq("rb_m_addr", dm.m_addr, 32'd0);
        check_eq("rb_m_we", 32'(dm.m_we), 32'd0);
        check_eq("rb_cpu_rdata", dm.cpu_rdata, 32'd0);
        check_eq("rb_dma_rdata", dm.dma_rdata, 32'd0);
        check_eq("rb_owner", 32'(dm.owner), 32'd0);
        check_eq("rb_dma_ack", 32'(dm.dma_ack), 32'd0);
        mem_auto = 1;

        // Continuous CPU and DMA traffic: grant order
`ifdef DMEM_ARB_RR_EN
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
        grants.delete();
        mem_wait = 0;
        dm.cpu_mem_r = 1; dm.cpu_addr = 32'h300;
        dm.dma_req = 1; dm.dma_we = 0; dm.dma_addr = 32'h400;
        for (int i = 0; i < 200 && grants.size() < 10; i++) @(negedge clk);
        dm.cpu_mem_r = 0; dm.dma_req = 0;
        check_eq("go_grant_count", 32'(grants.size() >= 10), 32'd1);
        for (int i = 0; i < 10; i++) begin
            g = (i < grants.size()) ? grants[i] : 1'bx;
            check_eq($sformatf("go_grant%0d", i), 32'(g), 32'(exp_order[i]));
        end
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
